seq_digit_gen: RTL and testbench

- Parametrised successor to the fixed 4-bit digit-sequence FSM.
- Steps through a programmable table of DIGIT_W-bit digits of runtime length, one step per enabled clock.
- Three playback modes: wrap, bounce and one-shot. Forward/backward direction applies in wrap mode.
- Feeds seven-segment and display demo logic. Emits a per-cycle digit, the current index, and boundary pulses.

---
 rtl/seq_digit_gen_pkg.sv | 37 +++
 rtl/seq_digit_store.sv | 52 +++++
 rtl/seq_digit_gen.sv | 162 ++++++++++++++++
 tb/tb_seq_digit_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_digit_gen_pkg.sv
// Shared types and helpers for the programmable digit-sequence generator.
// Optional writable table is selected with the SEQ_DIGIT_GEN_WR_EN macro.
package seq_digit_gen_pkg;

  // Entries 0..7 = 0,9,3,1,F,2,E,0 (entry 0 in the least significant nibble)
  localparam logic [31:0] SEQ_DEFAULT = 32'h0E2F_1390;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_BOUNCE  = 2'd1,
    MODE_ONESHOT = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_FWD  = 2'd0,
    ST_BWD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Active length is forced into 1..max_len
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    if (len == 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

  // Encoding 3 is not a mode of its own and plays back as wrap
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_BOUNCE;
      2'd2:    return MODE_ONESHOT;
      default: return MODE_WRAP;
    endcase
  endfunction

endpackage

// File: rtl/seq_digit_store.sv
// Digit table and index read mux; constant table by default, register file
// reloaded from SEQ on reset when SEQ_DIGIT_GEN_WR_EN is defined.
module seq_digit_store
  import seq_digit_gen_pkg::*;
#(
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned MAX_LEN = 8,
  parameter logic [DIGIT_W*MAX_LEN-1:0] SEQ = (DIGIT_W*MAX_LEN)'(SEQ_DEFAULT),
  localparam int unsigned IDX_W = $clog2(MAX_LEN)
) (
`ifdef SEQ_DIGIT_GEN_WR_EN
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [DIGIT_W-1:0] wr_data,
`endif
  input  logic [IDX_W-1:0]   idx,
  output logic [DIGIT_W-1:0] digit
);

  // Full power-of-two span so any idx value selects a defined entry
  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [DEPTH*DIGIT_W-1:0] flat;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [DIGIT_W-1:0] ent;

    if (i < MAX_LEN) begin : g_live
`ifdef SEQ_DIGIT_GEN_WR_EN
      // Addresses past MAX_LEN match no live entry, so those writes drop out
      always_ff @(posedge clk) begin
        if (reset) begin
          ent <= SEQ[i*DIGIT_W +: DIGIT_W];
        end else if (wr_en && (wr_addr == IDX_W'(i))) begin
          ent <= wr_data;
        end
      end
`else
      assign ent = SEQ[i*DIGIT_W +: DIGIT_W];
`endif
    end else begin : g_pad
      assign ent = '0;
    end

    assign flat[i*DIGIT_W +: DIGIT_W] = ent;
  end

  assign digit = flat[idx*DIGIT_W +: DIGIT_W];

endmodule

// File: rtl/seq_digit_gen.sv
// Programmable digit-sequence generator: wrap / bounce / one-shot playback.
// Define SEQ_DIGIT_GEN_WR_EN to add a runtime table write port.
module seq_digit_gen
  import seq_digit_gen_pkg::*;
#(
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned MAX_LEN = 8,
  parameter logic [DIGIT_W*MAX_LEN-1:0] SEQ = (DIGIT_W*MAX_LEN)'(SEQ_DEFAULT),
  localparam int unsigned IDX_W = $clog2(MAX_LEN),
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               restart,
  input  logic [LEN_W-1:0]   len,
  input  logic [1:0]         mode,
  input  logic               dir,
`ifdef SEQ_DIGIT_GEN_WR_EN
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [DIGIT_W-1:0] wr_data,
`endif
  output logic [DIGIT_W-1:0] digit,
  output logic [IDX_W-1:0]   idx,
  output logic               wrap_pulse,
  output logic               done
);

  state_e           state_q, state_nxt;
  mode_e            mode_q;
  logic [LEN_W-1:0] len_q;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic             pulse_q, pulse_nxt;
  logic             done_q, done_nxt;

  logic [IDX_W-1:0] last, idx_inc, idx_dec;
  logic             single, at_last, at_first;

  // Explicit endpoint compares; MAX_LEN need not be a power of two
  assign last     = IDX_W'(len_q - LEN_W'(1));
  assign idx_inc  = idx_q + IDX_W'(1);
  assign idx_dec  = idx_q - IDX_W'(1);
  assign single   = (last == '0);
  assign at_last  = (idx_q == last);
  assign at_first = (idx_q == '0);

  // State register; restart behaves as reset for everything but the table
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state_q <= ST_FWD;
      idx_q   <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      len_q   <= LEN_W'(clamp_len(32'(len), MAX_LEN));
      mode_q  <= decode_mode(mode);
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
      pulse_q <= pulse_nxt;
      done_q  <= done_nxt;
    end
  end

  // Next-state
  always_comb begin
    state_nxt = state_q;
    if (en) begin
      case (mode_q)
        MODE_BOUNCE: begin
          if (!single) begin
            case (state_q)
              ST_FWD:  if (idx_inc == last) state_nxt = ST_BWD;
              ST_BWD:  if (idx_dec == '0)   state_nxt = ST_FWD;
              default: state_nxt = ST_FWD;
            endcase
          end
        end
        MODE_ONESHOT: begin
          if ((state_q == ST_FWD) && (single || (idx_inc == last))) begin
            state_nxt = ST_DONE;
          end
        end
        default: state_nxt = ST_FWD;
      endcase
    end
  end

  // Index, boundary pulse and done flag for the coming edge
  always_comb begin
    idx_nxt   = idx_q;
    pulse_nxt = 1'b0;
    done_nxt  = done_q;
    if (en) begin
      case (mode_q)
        MODE_BOUNCE: begin
          if (single) begin
            pulse_nxt = 1'b1;
          end else if (state_q == ST_BWD) begin
            idx_nxt   = idx_dec;
            pulse_nxt = (idx_dec == '0);
          end else begin
            idx_nxt   = idx_inc;
            pulse_nxt = (idx_inc == last);
          end
        end
        MODE_ONESHOT: begin
          if (state_q != ST_DONE) begin
            if (single) begin
              pulse_nxt = 1'b1;
              done_nxt  = 1'b1;
            end else begin
              idx_nxt = idx_inc;
              if (idx_inc == last) begin
                pulse_nxt = 1'b1;
                done_nxt  = 1'b1;
              end
            end
          end
        end
        default: begin
          if (dir) begin
            if (at_first) begin
              idx_nxt   = last;
              pulse_nxt = 1'b1;
            end else begin
              idx_nxt = idx_dec;
            end
          end else begin
            if (at_last) begin
              idx_nxt   = '0;
              pulse_nxt = 1'b1;
            end else begin
              idx_nxt = idx_inc;
            end
          end
        end
      endcase
    end
  end

  seq_digit_store #(
    .DIGIT_W (DIGIT_W),
    .MAX_LEN (MAX_LEN),
    .SEQ     (SEQ)
  ) u_store (
`ifdef SEQ_DIGIT_GEN_WR_EN
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
`endif
    .idx     (idx_q),
    .digit   (digit)
  );

  assign idx        = idx_q;
  assign wrap_pulse = pulse_q;
  assign done       = done_q;

endmodule

// File: tb/tb_seq_digit_gen.sv
// Self-checking bench for seq_digit_gen: directed plan steps plus random
// traffic against a playback model derived from step counts and modular arithmetic.
module tb_seq_digit_gen;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned LEN_W   = 4;

  logic               clk = 1'b0;
  logic               reset, en, restart, dir;
  logic [LEN_W-1:0]   len;
  logic [1:0]         mode;
  logic [DIGIT_W-1:0] digit;
  logic [IDX_W-1:0]   idx;
  logic               wrap_pulse, done;
`ifdef SEQ_DIGIT_GEN_WR_EN
  logic               wr_en;
  logic [IDX_W-1:0]   wr_addr;
  logic [DIGIT_W-1:0] wr_data;
`endif

  int    total = 0;
  int    bad   = 0;
  string phase = "init";

  // Model: table contents plus playback position
  logic [3:0] seq_m [8] = '{4'h0, 4'h9, 4'h3, 4'h1, 4'hF, 4'h2, 4'hE, 4'h0};
  logic [3:0] m_tbl [8];
  int         m_len, m_mode, m_k, m_idx;
  bit         m_pulse, m_done;

  always #5 clk = ~clk;

  seq_digit_gen dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .restart    (restart),
    .len        (len),
    .mode       (mode),
    .dir        (dir),
`ifdef SEQ_DIGIT_GEN_WR_EN
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
`endif
    .digit      (digit),
    .idx        (idx),
    .wrap_pulse (wrap_pulse),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_load(input logic [3:0] l, input logic [1:0] m);
    m_len   = (l == 0) ? 1 : ((int'(l) > 8) ? 8 : int'(l));
    m_mode  = (m == 2'd3) ? 0 : int'(m);
    m_k     = 0;
    m_idx   = 0;
    m_pulse = 0;
    m_done  = 0;
  endtask

  // Bounce position is a triangle wave of the step count; one-shot saturates
  task automatic m_adv(input logic e, input logic d);
    int p, r;
    m_pulse = 0;
    if (!e) return;
    case (m_mode)
      1: begin
        if (m_len == 1) begin
          m_pulse = 1;
        end else begin
          m_k++;
          p = 2 * (m_len - 1);
          r = m_k % p;
          m_idx   = (r < m_len) ? r : p - r;
          m_pulse = (m_idx == 0) || (m_idx == m_len - 1);
        end
      end
      2: begin
        if (!m_done) begin
          m_k++;
          m_idx = (m_k < m_len - 1) ? m_k : m_len - 1;
          if (m_k == ((m_len > 1) ? m_len - 1 : 1)) begin
            m_done  = 1;
            m_pulse = 1;
          end
        end
      end
      default: begin
        if (d) begin
          m_pulse = (m_idx == 0);
          m_idx   = (m_idx + m_len - 1) % m_len;
        end else begin
          m_pulse = (m_idx == m_len - 1);
          m_idx   = (m_idx + 1) % m_len;
        end
      end
    endcase
  endtask

  // One clock: drive, advance model at the edge, compare all outputs
  task automatic cyc(input logic r, input logic rs, input logic e, input logic d,
                     input logic [3:0] l, input logic [1:0] m);
    reset = r; restart = rs; en = e; dir = d; len = l; mode = m;
    @(posedge clk);
    #1;
    if (r) begin
      m_load(l, m);
      m_tbl = seq_m;
    end else if (rs) begin
      m_load(l, m);
    end else begin
      m_adv(e, d);
    end
`ifdef SEQ_DIGIT_GEN_WR_EN
    if (!r && wr_en) m_tbl[wr_addr] = wr_data;
    wr_en = 1'b0;
`endif
    chk($sformatf("%s.idx", phase),   32'(idx),        32'(m_idx));
    chk($sformatf("%s.digit", phase), 32'(digit),      32'(m_tbl[m_idx]));
    chk($sformatf("%s.pulse", phase), 32'(wrap_pulse), 32'(m_pulse));
    chk($sformatf("%s.done", phase),  32'(done),       32'(m_done));
  endtask

  // len/mode wiggle freely during steps: they must be ignored
  task automatic step(input logic e, input logic d);
    cyc(1'b0, 1'b0, e, d, 4'($urandom), 2'($urandom));
  endtask

  task automatic rst_cyc(input logic [3:0] l, input logic [1:0] m);
    cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), l, m);
  endtask

  task automatic rs_cyc(input logic [3:0] l, input logic [1:0] m);
    cyc(1'b0, 1'b1, 1'($urandom), 1'($urandom), l, m);
  endtask

  initial begin
    logic [3:0] exp_wf [9];
    logic [2:0] exp_bi [8];
    int unsigned rr;
    exp_wf = '{4'h9, 4'h3, 4'h1, 4'hF, 4'h2, 4'hE, 4'h0, 4'h9, 4'h3};
    exp_bi = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
`ifdef SEQ_DIGIT_GEN_WR_EN
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
`endif

    phase = "reset";
    rst_cyc(4'd7, 2'd0);
    chk("reset.digit_lit", 32'(digit), 32'h0);

    phase = "wrap_fwd";
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0);
      chk("wrap_fwd.digit_lit", 32'(digit), 32'(exp_wf[i]));
      chk("wrap_fwd.pulse_lit", 32'(wrap_pulse), (i == 6) ? 32'd1 : 32'd0);
    end

    phase = "wrap_bwd";
    rs_cyc(4'd7, 2'd0);
    step(1'b1, 1'b1);
    chk("wrap_bwd.idx_lit", 32'(idx), 32'd6);
    chk("wrap_bwd.pulse_lit", 32'(wrap_pulse), 32'd1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("wrap_bwd.digit_lit", 32'(digit), 32'hF);
    step(1'b0, 1'b0);

    phase = "bounce";
    rs_cyc(4'd4, 2'd1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'($urandom));
      chk("bounce.idx_lit", 32'(idx), 32'(exp_bi[i]));
    end

    phase = "oneshot";
    rs_cyc(4'd3, 2'd2);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("oneshot.done_lit", 32'(done), 32'd1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("oneshot.hold_digit_lit", 32'(digit), 32'h3);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 2'd2);
    chk("oneshot.restart_done_lit", 32'(done), 32'd0);

    phase = "len0";
    for (int m = 0; m < 3; m++) begin
      rs_cyc(4'd0, 2'(m));
      for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom));
    end
    rs_cyc(4'd0, 2'd0);
    step(1'b1, 1'b0);
    chk("len0.pulse_lit", 32'(wrap_pulse), 32'd1);

    phase = "len12";
    rst_cyc(4'd12, 2'd0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    chk("len12.idx7_lit", 32'(idx), 32'd7);
    step(1'b1, 1'b0);
    chk("len12.wrap_lit", 32'(idx), 32'd0);

    phase = "bounce_reset";
    rs_cyc(4'd4, 2'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    rst_cyc(4'd4, 2'd1);
    step(1'b1, 1'b0);
    chk("bounce_reset.fwd_lit", 32'(idx), 32'd1);

    phase = "mode3";
    rs_cyc(4'd5, 2'd3);
    for (int i = 0; i < 12; i++) step(1'($urandom), 1'($urandom));

`ifdef SEQ_DIGIT_GEN_WR_EN
    phase = "write";
    rs_cyc(4'd7, 2'd0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'h7;
    step(1'b0, 1'b0);
    chk("write.same_idx_lit", 32'(digit), 32'h7);
    rs_cyc(4'd7, 2'd0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("write.restart_keep_lit", 32'(digit), 32'h7);
    rst_cyc(4'd7, 2'd0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("write.reset_reload_lit", 32'(digit), 32'h3);
`endif

    phase = "random";
    for (int n = 0; n < 800; n++) begin
      rr = $urandom_range(0, 99);
`ifdef SEQ_DIGIT_GEN_WR_EN
      wr_en   = ($urandom_range(0, 9) == 0);
      wr_addr = 3'($urandom);
      wr_data = 4'($urandom);
`endif
      if (rr < 1)      rst_cyc(4'($urandom), 2'($urandom));
      else if (rr < 5) rs_cyc(4'($urandom), 2'($urandom));
      else             step($urandom_range(0, 3) != 0, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
